// File: rtl/command_frame_controller.sv
// Command frame sequencer: decodes UART RX frames into register file / ALU strobes and returns replies.
// Optional inter-byte frame timeout is enabled by defining CMD_TIMEOUT_EN.
module command_frame_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int ALU_FUNC_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       rx_data,
    input  logic                        rx_data_valid,
    output logic [ADDRESS_WIDTH-1:0]    reg_file_address,
    output logic                        reg_file_write_enable,
    output logic [DATA_WIDTH-1:0]       reg_file_write_data,
    output logic                        reg_file_read_enable,
    input  logic [DATA_WIDTH-1:0]       reg_file_read_data,
    input  logic                        reg_file_read_data_valid,
    output logic                        alu_enable,
    output logic [ALU_FUNC_WIDTH-1:0]   alu_function,
    input  logic [2*DATA_WIDTH-1:0]     alu_result,
    input  logic                        alu_result_valid,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_data_valid,
    input  logic                        tx_busy,
`ifdef CMD_TIMEOUT_EN
    output logic                        timeout_flag,
`endif
    output logic                        frame_active
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] WR_ADDR    = 4'd1;
    localparam logic [3:0] WR_DATA    = 4'd2;
    localparam logic [3:0] RD_ADDR    = 4'd3;
    localparam logic [3:0] RD_WAIT    = 4'd4;
    localparam logic [3:0] OP_A       = 4'd5;
    localparam logic [3:0] OP_B       = 4'd6;
    localparam logic [3:0] ALU_FUNC   = 4'd7;
    localparam logic [3:0] ALU_WAIT   = 4'd8;
    localparam logic [3:0] TX_SEND    = 4'd9;
    localparam logic [3:0] TX_WAIT_HI = 4'd10;
    localparam logic [3:0] TX_WAIT_LO = 4'd11;

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'('hDD);

    logic [3:0]            state;
    logic [DATA_WIDTH-1:0] result_hi;
    logic                  tx_last;
    logic                  abort;

    assign frame_active = (state != IDLE);

`ifdef CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt;
    logic          counting;

    // Only states that are waiting for the next frame byte can time out
    assign counting = state inside {WR_ADDR, WR_DATA, RD_ADDR,
                                    OP_A, OP_B, ALU_FUNC};
    assign abort    = counting && !rx_data_valid &&
                      (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= abort;
            if (!counting || rx_data_valid || abort)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            reg_file_address      <= '0;
            reg_file_write_enable <= 1'b0;
            reg_file_write_data   <= '0;
            reg_file_read_enable  <= 1'b0;
            alu_enable            <= 1'b0;
            alu_function          <= '0;
            tx_data               <= '0;
            tx_data_valid         <= 1'b0;
            result_hi             <= '0;
            tx_last               <= 1'b0;
        end else begin
            reg_file_write_enable <= 1'b0;
            reg_file_read_enable  <= 1'b0;
            alu_enable            <= 1'b0;
            tx_data_valid         <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rx_data_valid) begin
                            unique case (1'b1)
                                rx_data == CMD_WR:     state <= WR_ADDR;
                                rx_data == CMD_RD:     state <= RD_ADDR;
                                rx_data == CMD_ALU_OP: state <= OP_A;
                                rx_data == CMD_ALU:    state <= ALU_FUNC;
                                default:               state <= IDLE;
                            endcase
                        end
                    end
                    WR_ADDR: begin
                        if (rx_data_valid) begin
                            reg_file_address <= rx_data[ADDRESS_WIDTH-1:0];
                            state            <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (rx_data_valid) begin
                            reg_file_write_data   <= rx_data;
                            reg_file_write_enable <= 1'b1;
                            state                 <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (rx_data_valid) begin
                            reg_file_address     <= rx_data[ADDRESS_WIDTH-1:0];
                            reg_file_read_enable <= 1'b1;
                            state                <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (reg_file_read_data_valid) begin
                            tx_data <= reg_file_read_data;
                            tx_last <= 1'b1;
                            state   <= TX_SEND;
                        end
                    end
                    OP_A: begin
                        if (rx_data_valid) begin
                            reg_file_address      <= '0;
                            reg_file_write_data   <= rx_data;
                            reg_file_write_enable <= 1'b1;
                            state                 <= OP_B;
                        end
                    end
                    OP_B: begin
                        if (rx_data_valid) begin
                            reg_file_address      <= ADDRESS_WIDTH'(1);
                            reg_file_write_data   <= rx_data;
                            reg_file_write_enable <= 1'b1;
                            state                 <= ALU_FUNC;
                        end
                    end
                    ALU_FUNC: begin
                        if (rx_data_valid) begin
                            alu_function <= rx_data[ALU_FUNC_WIDTH-1:0];
                            alu_enable   <= 1'b1;
                            state        <= ALU_WAIT;
                        end
                    end
                    ALU_WAIT: begin
                        if (alu_result_valid) begin
                            tx_data   <= alu_result[DATA_WIDTH-1:0];
                            result_hi <= alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                            tx_last   <= 1'b0;
                            state     <= TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (!tx_busy) begin
                            tx_data_valid <= 1'b1;
                            state         <= TX_WAIT_HI;
                        end
                    end
                    TX_WAIT_HI: begin
                        if (tx_busy)
                            state <= TX_WAIT_LO;
                    end
                    TX_WAIT_LO: begin
                        // tx_data may only change once the transmitter has released the byte
                        if (!tx_busy) begin
                            if (tx_last) begin
                                state <= IDLE;
                            end else begin
                                tx_data <= result_hi;
                                tx_last <= 1'b1;
                                state   <= TX_SEND;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_command_frame_controller.sv
// Bench for command_frame_controller: frame-level model, reg file / ALU / UART TX responders.
// Timeout scenario is exercised when CMD_TIMEOUT_EN is defined.
module tb_command_frame_controller;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_data_valid = 1'b0;
    logic [AW-1:0] reg_file_address;
    logic          reg_file_write_enable;
    logic [DW-1:0] reg_file_write_data;
    logic          reg_file_read_enable;
    logic [DW-1:0] reg_file_read_data = '0;
    logic          reg_file_read_data_valid = 1'b0;
    logic          alu_enable;
    logic [FW-1:0] alu_function;
    logic [2*DW-1:0] alu_result = '0;
    logic          alu_result_valid = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_data_valid;
    logic          tx_busy = 1'b0;
    logic          frame_active;
`ifdef CMD_TIMEOUT_EN
    logic          timeout_flag;
`endif

    command_frame_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .ALU_FUNC_WIDTH(FW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .reg_file_address(reg_file_address),
        .reg_file_write_enable(reg_file_write_enable),
        .reg_file_write_data(reg_file_write_data),
        .reg_file_read_enable(reg_file_read_enable),
        .reg_file_read_data(reg_file_read_data),
        .reg_file_read_data_valid(reg_file_read_data_valid),
        .alu_enable(alu_enable), .alu_function(alu_function),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy),
`ifdef CMD_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // frame-level expectations and observation bookkeeping
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  obs_tx[$];
    int wr_idx = 0, rd_idx = 0, alu_idx = 0, tx_idx = 0, obs_idx = 0;
    int wr_count = 0;
    logic [3:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;
    logic [3:0] last_func = '0;
    logic [7:0] mrf [16] = '{default: 8'h00};
    logic [7:0] rsp_mem [16] = '{default: 8'h00};
    int rd_cnt = 0, alu_cnt = 0, busy_cnt = 0;
    logic [3:0] rd_addr = '0;
    logic [3:0] alu_func_seen = '0;
    logic [7:0] tx_hold = '0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [15:0] alu_calc(input logic [3:0] f,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return 16'(a & b);
            default: return 16'(a ^ b);
        endcase
    endfunction

    task automatic mon_step();
        if (!reset) begin
            if (reg_file_write_enable) begin
                chk("wr_expected", 32'(wr_idx < exp_wr.size()), 1);
                if (wr_idx < exp_wr.size()) begin
                    chk("wr_addr", 32'(reg_file_address), 32'(exp_wr[wr_idx][11:8]));
                    chk("wr_data", 32'(reg_file_write_data), 32'(exp_wr[wr_idx][7:0]));
                    wr_idx++;
                end
                rsp_mem[reg_file_address] = reg_file_write_data;
                last_wr_addr = reg_file_address;
                last_wr_data = reg_file_write_data;
                wr_count++;
            end
            if (reg_file_read_enable) begin
                chk("rd_expected", 32'(rd_idx < exp_rd.size()), 1);
                if (rd_idx < exp_rd.size()) begin
                    chk("rd_addr", 32'(reg_file_address), 32'(exp_rd[rd_idx]));
                    rd_idx++;
                end
                rd_addr = reg_file_address;
                rd_cnt = 3;
            end
            if (alu_enable) begin
                chk("alu_expected", 32'(alu_idx < exp_alu.size()), 1);
                if (alu_idx < exp_alu.size()) begin
                    chk("alu_func", 32'(alu_function), 32'(exp_alu[alu_idx]));
                    alu_idx++;
                end
                alu_func_seen = alu_function;
                last_func = alu_function;
                alu_cnt = 2;
            end
            if (tx_data_valid) begin
                chk("tx_line_idle", 32'(tx_busy), 0);
                chk("tx_expected", 32'(tx_idx < exp_tx.size()), 1);
                if (tx_idx < exp_tx.size()) begin
                    chk("tx_data", 32'(tx_data), 32'(exp_tx[tx_idx]));
                    tx_idx++;
                end
                obs_tx.push_back(tx_data);
                tx_hold = tx_data;
                busy_cnt = 6;
            end else if (tx_busy) begin
                chk("tx_stable", 32'(tx_data), 32'(tx_hold));
            end
        end
        reg_file_read_data_valid = 1'b0;
        alu_result_valid = 1'b0;
        if (reset) begin
            rd_cnt = 0;
            alu_cnt = 0;
            busy_cnt = 0;
            tx_busy = 1'b0;
        end else begin
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    reg_file_read_data_valid = 1'b1;
                    reg_file_read_data = rsp_mem[rd_addr];
                end
            end
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_result_valid = 1'b1;
                    alu_result = alu_calc(alu_func_seen, rsp_mem[0], rsp_mem[1]);
                end
            end
            if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [15:0] r;
        logic [3:0] a;
        logic [3:0] f;
        case (b0)
            8'hAA: begin
                a = b1[3:0];
                exp_wr.push_back({a, b2});
                mrf[a] = b2;
            end
            8'hBB: begin
                a = b1[3:0];
                exp_rd.push_back(a);
                exp_tx.push_back(mrf[a]);
            end
            8'hCC: begin
                exp_wr.push_back({4'd0, b1});
                exp_wr.push_back({4'd1, b2});
                mrf[0] = b1;
                mrf[1] = b2;
                f = b3[3:0];
                r = alu_calc(f, b1, b2);
                exp_alu.push_back(f);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
            8'hDD: begin
                f = b1[3:0];
                r = alu_calc(f, mrf[0], mrf[1]);
                exp_alu.push_back(f);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
            default: ;
        endcase
    endtask

    task automatic do_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] b [4];
        b = '{b0, b1, b2, b3};
        model_frame(b0, b1, b2, b3);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #2;
            done = (wr_idx == exp_wr.size()) && (rd_idx == exp_rd.size()) &&
                   (alu_idx == exp_alu.size()) && (tx_idx == exp_tx.size()) &&
                   !frame_active && !tx_busy;
        end
        chk(name, 32'(done), 1);
    endtask

    task automatic expect_tx(input string name, input logic [7:0] v);
        logic [7:0] g;
        g = 'x;
        if (obs_idx < obs_tx.size()) begin
            g = obs_tx[obs_idx];
            obs_idx++;
        end
        chk(name, 32'(g), 32'(v));
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_we"}, 32'(reg_file_write_enable), 0);
        chk({tag, "_re"}, 32'(reg_file_read_enable), 0);
        chk({tag, "_alu_en"}, 32'(alu_enable), 0);
        chk({tag, "_txv"}, 32'(tx_data_valid), 0);
        chk({tag, "_addr"}, 32'(reg_file_address), 0);
        chk({tag, "_wdata"}, 32'(reg_file_write_data), 0);
        chk({tag, "_func"}, 32'(alu_function), 0);
        chk({tag, "_txd"}, 32'(tx_data), 0);
        chk({tag, "_active"}, 32'(frame_active), 0);
    endtask

    initial begin
        int w0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            begin
                reset = 1'b1;
                repeat (3) @(negedge clk);
                zero_check("rst");
                reset = 1'b0;
                @(negedge clk);

                // plain write
                model_frame(8'hAA, 8'h05, 8'h3C, 8'h00);
                send_byte(8'hAA);
                chk("t1_active", 32'(frame_active), 1);
                send_byte(8'h05);
                send_byte(8'h3C);
                wait_idle("t1_done");
                chk("t1_addr", 32'(last_wr_addr), 'h5);
                chk("t1_data", 32'(last_wr_data), 'h3C);
                chk("t1_wcount", 32'(wr_count), 1);

                // read back
                do_frame(2, 8'hBB, 8'h05, 8'h00, 8'h00);
                wait_idle("t2_done");
                expect_tx("t2_tx", 8'h3C);

                // ALU with operands: 0x0A + 0x03
                do_frame(4, 8'hCC, 8'h0A, 8'h03, 8'h00);
                wait_idle("t3_done");
                chk("t3_wcount", 32'(wr_count), 3);
                chk("t3_func", 32'(last_func), 0);
                expect_tx("t3_tx_lo", 8'h0D);
                expect_tx("t3_tx_hi", 8'h00);

                // ALU without operands: 0x0A * 0x03
                w0 = wr_count;
                do_frame(2, 8'hDD, 8'h02, 8'h00, 8'h00);
                wait_idle("t4_done");
                chk("t4_nowrite", 32'(wr_count), 32'(w0));
                chk("t4_func", 32'(last_func), 2);
                expect_tx("t4_tx_lo", 8'h1E);
                expect_tx("t4_tx_hi", 8'h00);

                // junk byte, then reset mid-frame
                w0 = wr_count;
                send_byte(8'h55);
                chk("t5_junk_idle", 32'(frame_active), 0);
                send_byte(8'hAA);
                send_byte(8'h07);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                zero_check("t5");
                reset = 1'b0;
                repeat (4) @(negedge clk);
                chk("t5_nowrite", 32'(wr_count), 32'(w0));

                do_frame(3, 8'hAA, 8'h01, 8'hFF, 8'h00);
                wait_idle("t6_done");
                chk("t6_addr", 32'(last_wr_addr), 'h1);
                chk("t6_data", 32'(last_wr_data), 'hFF);

                // upper address bits ignored; bytes during wait/TX dropped
                w0 = wr_count;
                do_frame(2, 8'hBB, 8'h10, 8'h00, 8'h00);
                send_byte(8'hAA);
                send_byte(8'h09);
                send_byte(8'h77);
                wait_idle("t7_done");
                chk("t7_nowrite", 32'(wr_count), 32'(w0));
                expect_tx("t7_tx", 8'h0A);

                // function byte upper bits ignored: 0xF4 - 0x02
                do_frame(4, 8'hCC, 8'hF4, 8'h02, 8'h31);
                wait_idle("t8_done");
                chk("t8_func", 32'(last_func), 1);
                expect_tx("t8_tx_lo", 8'hF2);
                expect_tx("t8_tx_hi", 8'h00);

`ifdef CMD_TIMEOUT_EN
                begin
                    bit seen;
                    int n;
                    seen = 1'b0;
                    n = 0;
                    send_byte(8'hAA);
                    for (int i = 0; i < TO + 50 && !seen; i++) begin
                        @(negedge clk);
                        n++;
                        if (timeout_flag) seen = 1'b1;
                    end
                    chk("to_flag", 32'(seen), 1);
                    chk("to_not_early", 32'(n >= TO - 10), 1);
                    @(negedge clk);
                    chk("to_pulse", 32'(timeout_flag), 0);
                    chk("to_idle", 32'(frame_active), 0);
                    do_frame(3, 8'hAA, 8'h01, 8'hFF, 8'h00);
                    wait_idle("to_next_done");
                    chk("to_next_data", 32'(last_wr_data), 'hFF);
                end
`endif
                repeat (5) @(negedge clk);
            end
        join_any
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
